// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: 3-stage pipelined WIDTH x WIDTH Wallace-tree multiplier, signed/unsigned per beat,
// valid/ready handshake with a single stall that freezes every stage.
module wallace_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int PW = 2 * WIDTH;
    localparam int ROWS = WIDTH + 1;
    localparam logic [PW-1:0] BW_K = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    function automatic int layers(input int rows);
        int m = rows;
        int l = 0;
        while (m > 2) begin
            m = 2 * (m / 3) + m % 3;
            l++;
        end
        return l;
    endfunction

    localparam int LAYERS = layers(ROWS);

    logic stall;
    logic v1, v2, sg1;
    logic [WIDTH-1:0] a1, b1;
    logic [TAG_W-1:0] t1, t2;
    logic [PW-1:0] sum2, car2;
    logic [PW-1:0] pp [ROWS];
    logic [PW-1:0] r [ROWS];
    logic [PW-1:0] nx [ROWS];
    int n;

    assign stall = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Baugh-Wooley: cross terms involving exactly one sign bit are inverted; the extra row is the correction constant
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        localparam logic [WIDTH-1:0] FLIP = (i == WIDTH - 1) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        assign pp[i] = PW'((a1 & {WIDTH{b1[i]}}) ^ ({WIDTH{sg1}} & FLIP)) << i;
    end
    assign pp[WIDTH] = {PW{sg1}} & BW_K;

    // Wallace layers: every full group of three rows becomes a sum row and a shifted carry row
    always_comb begin
        r = pp;
        nx = '{default: '0};
        n = ROWS;
        for (int l = 0; l < LAYERS; l++) begin
            nx = '{default: '0};
            for (int k = 0; k < ROWS / 3; k++) begin
                if (k < n / 3) begin
                    nx[2*k]   = r[3*k] ^ r[3*k+1] ^ r[3*k+2];
                    nx[2*k+1] = ((r[3*k] & r[3*k+1]) | (r[3*k+2] & (r[3*k] | r[3*k+1]))) << 1;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (k < n % 3) nx[2*(n/3)+k] = r[3*(n/3)+k];
            end
            n = 2 * (n / 3) + n % 3;
            r = nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            sg1 <= 1'b0;
            t1 <= '0;
            sum2 <= '0;
            car2 <= '0;
            t2 <= '0;
            out_p <= '0;
            out_tag <= '0;
        end else if (!stall) begin
            v1 <= in_valid;
            v2 <= v1;
            out_valid <= v2;
            if (in_valid) begin
                a1 <= in_a;
                b1 <= in_b;
                sg1 <= in_signed;
                t1 <= in_tag;
            end
            if (v1) begin
                sum2 <= r[0];
                car2 <= r[1];
                t2 <= t1;
            end
            if (v2) begin
                out_p <= sum2 + car2;
                out_tag <= t2;
            end
        end
    end
endmodule
